// File: rtl/cross_bar_slave_mem.sv
// cross_bar_slave_mem: single-port memory responder for one crossbar slave port.
// Latency: accept edge E0, slave_ack high in the cycle after E0+W+1; one idle cycle follows each ack.
// Backpressure: one transaction in flight; slave_req is ignored outside IDLE, so the requester holds it until ack.
//
// Ports:
//   clk          block clock, rising edge
//   areset       asynchronous active-high reset (clears FSM, outputs and memory)
//   slave_req    request valid, sampled only in IDLE
//   slave_addr   byte address, word index = slave_addr[MEM_AW+1:2]
//   slave_cmd    1 = write, 0 = read
//   slave_wdata  write data
//   slave_ack    one-cycle completion pulse
//   slave_rdata  read data, updated only by read completions
//
// Optional feature: define SLAVE_MEM_RANDOM_WAIT_EN to draw the wait-state count per
// transaction from an 8-bit LFSR (lfsr % (WAIT_CYCLES+1)); otherwise every transaction
// uses WAIT_CYCLES wait states.

module cross_bar_slave_mem #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_AW      = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          wait_cnt;
  logic [7:0]          wait_load;
  logic [MEM_AW-1:0]   idx_q;
  logic                cmd_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic                done;

  // Only the word-index bits of the address matter; the rest are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{slave_addr[ADDR_W-1:MEM_AW+2], slave_addr[1:0]};

  assign accept    = (state == ST_IDLE) && slave_req;
  // Last wait cycle: the memory access happens on the edge that moves to ACK.
  assign done      = (state == ST_WAIT) && (wait_cnt == 8'd0);
  assign slave_ack = (state == ST_ACK);

`ifdef SLAVE_MEM_RANDOM_WAIT_EN
  // 9-bit modulus so WAIT_CYCLES=255 (modulus 256) does not overflow.
  localparam logic [8:0] WAIT_MOD = 9'(WAIT_CYCLES + 1);

  logic [7:0] lfsr;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted transaction.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // The wait count uses the LFSR value present at the accept edge, before it steps.
  assign wait_load = 8'({1'b0, lfsr} % WAIT_MOD);
`else
  assign wait_load = 8'(WAIT_CYCLES);
`endif

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A request dropped during WAIT does not abort the transaction.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (slave_req) state_nxt = ST_WAIT;
      ST_WAIT: if (wait_cnt == 8'd0) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and wait counter. Inputs are only looked at on the accept edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wait_cnt <= 8'd0;
      idx_q    <= '0;
      cmd_q    <= 1'b0;
      wdata_q  <= '0;
    end else if (accept) begin
      wait_cnt <= wait_load;
      idx_q    <= slave_addr[MEM_AW+1:2];
      cmd_q    <= slave_cmd;
      wdata_q  <= slave_wdata;
    end else if ((state == ST_WAIT) && (wait_cnt != 8'd0)) begin
      wait_cnt <= wait_cnt - 8'd1;
    end
  end

  // Memory and read-data register. Reset clears every word so a transaction
  // interrupted by reset leaves no trace.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      slave_rdata <= '0;
    end else if (done) begin
      if (cmd_q) begin
        mem[idx_q] <= wdata_q;
      end else begin
        slave_rdata <= mem[idx_q];
      end
    end
  end

endmodule

// File: tb/tb_cross_bar_slave_mem.sv
// Bench for cross_bar_slave_mem: a timeline model of the main instance is checked
// every cycle, plus directed transactions with literal expectations. A second
// instance with zero wait states covers back-to-back acceptance.
module tb_cross_bar_slave_mem;

`ifdef SLAVE_MEM_RANDOM_WAIT_EN
  localparam int W_MAIN = 3;
`else
  localparam int W_MAIN = 2;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic        req1, cmd1, ack1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        req0, cmd0, ack0;
  logic [31:0] addr0, wdata0, rdata0;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  always #5 clk = ~clk;

  cross_bar_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_AW(4), .WAIT_CYCLES(W_MAIN)) u_dut (
    .clk(clk), .areset(areset), .slave_req(req1), .slave_addr(addr1), .slave_cmd(cmd1),
    .slave_wdata(wdata1), .slave_ack(ack1), .slave_rdata(rdata1));

  cross_bar_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_AW(4), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .areset(areset), .slave_req(req0), .slave_addr(addr0), .slave_cmd(cmd0),
    .slave_wdata(wdata0), .slave_ack(ack0), .slave_rdata(rdata0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- timeline model of the main instance ----------------
  logic [31:0] m_mem [16];
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  int          m_edge = 0, m_free = 0, m_ack_edge = -1, m_w = 0;
  logic        m_cmd = 1'b0;
  logic [3:0]  m_idx = '0;
  logic [31:0] m_wd = '0;
  logic [7:0]  m_lfsr = 8'hA5;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_rdata = '0; m_ack = 1'b0; m_edge = 0; m_free = 0; m_ack_edge = -1; m_lfsr = 8'hA5;
    end else begin
      m_edge++;
      m_ack = (m_edge == m_ack_edge);
      if (m_ack) begin
        if (m_cmd) m_mem[m_idx] = m_wd;
        else       m_rdata = m_mem[m_idx];
      end
      if (m_edge >= m_free && req1) begin
`ifdef SLAVE_MEM_RANDOM_WAIT_EN
        m_w = int'(m_lfsr) % (W_MAIN + 1);
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
`else
        m_w = W_MAIN;
`endif
        m_ack_edge = m_edge + m_w + 1;
        m_free     = m_edge + m_w + 3;
        m_idx = addr1[5:2]; m_cmd = cmd1; m_wd = wdata1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ack_vs_model", {31'b0, ack1}, {31'b0, m_ack});
      chk("rdata_vs_model", rdata1, m_rdata);
    end
  end

  // ---------------- driver ----------------
  // Called on a negedge with the target idle; returns on a negedge one idle cycle after ack.
  // lat = edges from accept to the edge that raises ack.
  task automatic txn(input bit sel0, input logic [31:0] a, input logic c, input logic [31:0] wd,
                     input logic [31:0] wd_late, output int lat, output logic [31:0] rd);
    int k;
    bit seen;
    if (sel0) begin req0 = 1'b1; addr0 = a; cmd0 = c; wdata0 = wd; end
    else      begin req1 = 1'b1; addr1 = a; cmd1 = c; wdata1 = wd; end
    @(posedge clk);
    k = 0; seen = 0;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (sel0) wdata0 = wd_late; else wdata1 = wd_late;
      end
      seen = sel0 ? ack0 : ack1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL ack_timeout: no ack after %0d cycles, addr %h", k, a);
    end
    lat = k - 1;
    rd  = sel0 ? rdata0 : rdata1;
    if (sel0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  int          lat;
  logic [11:0] acks;
`ifdef SLAVE_MEM_RANDOM_WAIT_EN
  int lat_q0[$], lat_q1[$];
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    req1 = 0; cmd1 = 0; addr1 = '0; wdata1 = '0;
    req0 = 0; cmd0 = 0; addr0 = '0; wdata0 = '0;
    areset = 1'b0;
    #2 areset = 1'b1;
    started = 1;
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'b0, ack1}, 32'd0);
    chk("reset_rdata", rdata1, 32'd0);
    areset = 1'b0;
    @(negedge clk);

    // Write then read.
    txn(0, 32'ha0000000, 1, 32'hdeadc0de, 32'hdeadc0de, lat, rd);
`ifndef SLAVE_MEM_RANDOM_WAIT_EN
    chk("wr_latency", lat, 32'd3);
`endif
    chk("wr_rdata_unchanged", rd, 32'd0);
    txn(0, 32'ha0000000, 0, 32'h0, 32'h0, lat, rd);
`ifndef SLAVE_MEM_RANDOM_WAIT_EN
    chk("rd_latency", lat, 32'd3);
`endif
    chk("rd_data", rd, 32'hdeadc0de);

    // Alias / wrap.
    txn(0, 32'hd2000004, 1, 32'h0f0f0f0f, 32'h0f0f0f0f, lat, rd);
    chk("wr_keeps_prev_rdata", rd, 32'hdeadc0de);
    txn(0, 32'h00000044, 0, 32'h0, 32'h0, lat, rd);
    chk("alias_word1", rd, 32'h0f0f0f0f);
    txn(0, 32'h00000040, 0, 32'h0, 32'h0, lat, rd);
    chk("wrap_word0", rd, 32'hdeadc0de);

    // Low address bits ignored.
    txn(0, 32'h00000013, 1, 32'h44444444, 32'h44444444, lat, rd);
    txn(0, 32'h00000010, 0, 32'h0, 32'h0, lat, rd);
    chk("byte_offset_ignored", rd, 32'h44444444);

    // Write data changed after accept.
    txn(0, 32'h00000008, 1, 32'h11111111, 32'h22222222, lat, rd);
    txn(0, 32'h00000008, 0, 32'h0, 32'h0, lat, rd);
    chk("wdata_latched_at_accept", rd, 32'h11111111);

    // Set a nonzero rdata, then reset in the middle of a write to word 3.
    txn(0, 32'h00000004, 0, 32'h0, 32'h0, lat, rd);
    chk("pre_reset_read", rd, 32'h0f0f0f0f);
    req1 = 1'b1; addr1 = 32'h0000000c; cmd1 = 1'b1; wdata1 = 32'h33333333;
    @(posedge clk);
    @(negedge clk);
    #2 areset = 1'b1;
    #1;
    chk("in_reset_ack", {31'b0, ack1}, 32'd0);
    chk("in_reset_rdata", rdata1, 32'd0);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    txn(0, 32'h0000000c, 0, 32'h0, 32'h0, lat, rd);
    chk("reset_drops_write", rd, 32'd0);
    txn(0, 32'h00000000, 0, 32'h0, 32'h0, lat, rd);
    chk("reset_clears_mem", rd, 32'd0);

    // Back-to-back on the zero-wait instance with req held for 9 cycles.
    acks = '0;
    for (int i = 0; i < 12; i++) begin
      acks[i] = ack0;
      if (i < 9) begin
        req0 = 1'b1; cmd0 = 1'b1; addr0 = 32'(i * 4); wdata0 = 32'h100 + 32'(i);
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_ack_pattern", {20'b0, acks}, 32'h124);
    txn(1, 32'h00000000, 0, 32'h0, 32'h0, lat, rd);
    chk("b2b_w0_latency", lat, 32'd1);
    chk("b2b_word0", rd, 32'h100);
    txn(1, 32'h0000000c, 0, 32'h0, 32'h0, lat, rd);
    chk("b2b_word3", rd, 32'h103);
    txn(1, 32'h00000018, 0, 32'h0, 32'h0, lat, rd);
    chk("b2b_word6", rd, 32'h106);
    txn(1, 32'h00000004, 0, 32'h0, 32'h0, lat, rd);
    chk("b2b_word1_untouched", rd, 32'd0);

`ifdef SLAVE_MEM_RANDOM_WAIT_EN
    // Random wait states: two identical runs separated by reset.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      #2 areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 200; i++) begin
        txn(0, 32'((i * 4) % 64), (i % 3) != 0, 32'(i) * 32'h01010101 ^ 32'h5a5a0000,
            32'hffffffff, lat, rd);
        chk("rand_lat_range", {31'b0, (lat >= 1 && lat <= W_MAIN + 1)}, 32'd1);
        if (r == 0) lat_q0.push_back(lat); else lat_q1.push_back(lat);
      end
    end
    for (int i = 0; i < 200; i++) begin
      chk("rand_lat_repeat", lat_q1[i], lat_q0[i]);
    end
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cross_bar_slave_mem.md
# cross_bar_slave_mem

Synthesizable single-port memory responder for the slave side of the cross_bar_top request/acknowledge bus. It accepts one transaction at a time (`cmd`=1 write, `cmd`=0 read) on `slave_req`/`slave_addr`/`slave_cmd`/`slave_wdata`. After a programmable number of wait states it answers with a one-cycle `slave_ack` and, for reads, `slave_rdata`. One instance connects to each crossbar slave port and serves as a real endpoint in system simulation and on FPGA.

## Interface
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, data width
- `MEM_AW`, 4, log2 of memory depth in words (default 16 words)
- `WAIT_CYCLES`, 2, wait states between accept and ack (0..255)
- `clk`  input  1  block clock; all logic on rising edge
- `areset`  input  1  asynchronous, active-high reset
- `slave_req`  input  1  request valid; held by requester until ack seen
- `slave_addr`  input  ADDR_W  byte address; word index = `addr[MEM_AW+1:2]`, other bits ignored
- `slave_cmd`  input  1  1 = write, 0 = read
- `slave_wdata`  input  DATA_W  write data
- `slave_ack`  output  1  one-cycle completion pulse
- `slave_rdata`  output  DATA_W  read data; valid in ack cycle, held until next read ack

## Operation
- Reset (async assert, sync release): state=IDLE, `slave_ack`=0, `slave_rdata`=0, wait counter=0, all memory words=0, LFSR=8'hA5.
- FSM states:
  - IDLE: `req`=1 at edge → latch addr index, cmd, wdata; load counter; go to WAIT. `req`=0 → stay.
  - WAIT: counter≠0 → decrement. Counter==0 → go to ACK. At that edge a write commits the latched wdata to memory; a read loads `slave_rdata` from memory.
  - ACK: `slave_ack`=1 for exactly this cycle; next edge → IDLE unconditionally.
- Request inputs are sampled only at the accept edge. Later changes to addr/wdata/cmd do not affect the transaction in flight.
- Write ack: `slave_rdata` is unchanged.
- `req` deasserted during WAIT: the transaction still completes and is acked. No abort.
- `req` still high in IDLE after ACK (stale or new) is accepted as a new transaction. Requesters must drop `req` on the edge after seeing ack.
- Address wrap: index uses only `addr[MEM_AW+1:2]`; word (2^MEM_AW)−1 +1 wraps to word 0; `addr[1:0]` ignored.
- Reset mid-transaction: the transaction is dropped with no ack and no write; memory is cleared.

## Timing
- Accept edge E0 (IDLE, `req`=1). With W wait states, `slave_ack` is high in the cycle following edge E0+W+1.
- `ack` falls at E0+W+2. The earliest next accept is edge E0+W+3, giving 1 guaranteed idle cycle.
- W=0: ack in the cycle after E0+1. Throughput is 1 transaction per W+3 cycles.
- A read returns data written by any earlier acked write, with no hazard, because only one transaction is ever in flight.

## Configuration
- `SLAVE_MEM_RANDOM_WAIT_EN` defined: W is taken per transaction from an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) as `lfsr % (WAIT_CYCLES+1)`. The LFSR advances once per accept edge. Latency is therefore bounded in [1, WAIT_CYCLES+1] cycles to ack.
- Not defined: W = WAIT_CYCLES for every transaction and no LFSR is instantiated.

## Test plan
- Write then read, WAIT_CYCLES=2:
  - write 0xa0000000 ← 0xdeadc0de → ack in the cycle after E0+3; `slave_rdata` stays 0.
  - read 0xa0000000 → ack with `slave_rdata`=0xdeadc0de.
- Alias/wrap with MEM_AW=4:
  - write 0xd2000004 ← 0x0f0f0f0f, then read 0x00000044 → 0x0f0f0f0f.
  - read 0x00000040 → the word-0 contents.
- Back-to-back, WAIT_CYCLES=0, `req` held high for 3 transactions → exactly 3 one-cycle acks spaced 3 cycles apart; each uses the inputs latched at its own accept edge.
- Input change during WAIT: `slave_wdata` changed from 0x11111111 to 0x22222222 after accept → memory holds 0x11111111 (verified by readback).
- Reset mid-op: assert `areset` during WAIT of a write to word 3 → no ack; readback after release returns 0; all outputs 0 while in reset.
- With `SLAVE_MEM_RANDOM_WAIT_EN`, WAIT_CYCLES=3, 200 random transactions → every ack within 1..4 cycles after accept; data matches the scoreboard; the latency sequence is identical across two runs.
